shell_sched: RTL and testbench

SHELL_SCHED -- requirements
Module: shell_sched

---
 rtl/shell_sched_pkg.sv | 65 ++++++
 rtl/shell_sched_rr_arbiter.sv | 25 ++
 rtl/shell_sched.sv | 144 ++++++++++++++
 tb/tb_shell_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/shell_sched_pkg.sv
// Shared constants, types and slot helpers for the shell scheduler.
package shell_sched_pkg;

    localparam int NUM_REQ  = 4;
    localparam int NUM_SLOT = 4;
    localparam int CW       = 5;

    localparam logic [CW-1:0] X_MAX     = 5'd24;
    localparam logic [CW-1:0] Y_MAX     = 5'd12;
    localparam logic [CW-1:0] OFF_FIELD = 5'd31;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef struct packed {
        logic          act;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        dir_e          dir;
        logic [1:0]    owner;
    } slot_t;

    // Slot sitting on the field edge it is heading towards.
    function automatic logic at_edge(input slot_t s);
        logic e;
        e = 1'b0;
        case (s.dir)
            DIR_UP:    e = (s.y == 5'd0);
            DIR_DOWN:  e = (s.y == Y_MAX);
            DIR_LEFT:  e = (s.x == 5'd0);
            DIR_RIGHT: e = (s.x == X_MAX);
            default:   e = 1'b0;
        endcase
        return e;
    endfunction

    // Advance a slot by one cell in its stored direction.
    function automatic slot_t step_slot(input slot_t s);
        slot_t n;
        n = s;
        case (s.dir)
            DIR_UP:    n.y = s.y - 5'd1;
            DIR_DOWN:  n.y = s.y + 5'd1;
            DIR_LEFT:  n.x = s.x - 5'd1;
            DIR_RIGHT: n.x = s.x + 5'd1;
            default:   n = s;
        endcase
        return n;
    endfunction

    // Drop a slot off the field; direction and owner are left as they were.
    function automatic slot_t retire_slot(input slot_t s);
        slot_t n;
        n     = s;
        n.act = 1'b0;
        n.x   = OFF_FIELD;
        n.y   = OFF_FIELD;
        return n;
    endfunction

endpackage

// File: rtl/shell_sched_rr_arbiter.sv
// Four-way combinational round-robin arbiter; search starts at ptr_i.
module rr_arbiter_4
    import shell_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic [1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_o = '0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr_i + 2'(i);
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shell_sched.sv
// Shell scheduler: grants shoot requests to free slots round-robin and
// moves/retires shells in flight. All outputs come straight from flops.
module shell_sched
    import shell_sched_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     tick,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CW-1:0]    tank_x,
    input  logic [NUM_REQ*CW-1:0]    tank_y,
    input  logic [NUM_REQ*2-1:0]     tank_dir,
    input  logic [NUM_SLOT-1:0]      kill,
    output logic [NUM_SLOT*CW-1:0]   shell_x,
    output logic [NUM_SLOT*CW-1:0]   shell_y,
    output logic [NUM_SLOT-1:0]      shell_act,
    output logic [NUM_REQ-1:0]       busy,
    output logic [NUM_REQ-1:0]       grant
);

    slot_t              slot_q [NUM_SLOT];
    slot_t              slot_d [NUM_SLOT];
    logic [NUM_REQ-1:0] busy_q, busy_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [1:0]         ptr_q, ptr_d;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [1:0]         win_idx;
    logic               slot_free;
    logic [1:0]         free_idx;
    logic [CW-1:0]      win_x, win_y;
    logic [1:0]         win_dir;

    assign elig = enable ? (req & ~busy_q) : '0;

    rr_arbiter_4 u_arb (
        .req_i (elig),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    // Lowest-numbered slot that is inactive going into this edge.
    always_comb begin
        slot_free = 1'b0;
        free_idx  = '0;
        for (int s = NUM_SLOT - 1; s >= 0; s--) begin
            if (!slot_q[s].act) begin
                slot_free = 1'b1;
                free_idx  = 2'(s);
            end
        end
    end

    // Encode the winning tank and fetch its position and heading.
    always_comb begin
        win_idx = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (arb_gnt[r]) win_idx = 2'(r);
        end
        case (win_idx)
            2'd0:    begin win_x = tank_x[4:0];   win_y = tank_y[4:0];   win_dir = tank_dir[1:0]; end
            2'd1:    begin win_x = tank_x[9:5];   win_y = tank_y[9:5];   win_dir = tank_dir[3:2]; end
            2'd2:    begin win_x = tank_x[14:10]; win_y = tank_y[14:10]; win_dir = tank_dir[5:4]; end
            default: begin win_x = tank_x[19:15]; win_y = tank_y[19:15]; win_dir = tank_dir[7:6]; end
        endcase
    end

    // Next state: kill beats movement, new shells skip the coincident tick,
    // busy is rebuilt from the owners of slots active after this edge.
    always_comb begin
        for (int s = 0; s < NUM_SLOT; s++) slot_d[s] = slot_q[s];
        busy_d  = busy_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (enable) begin
            grant_d = '0;
            for (int s = 0; s < NUM_SLOT; s++) begin
                if (slot_q[s].act) begin
                    if (kill[s]) begin
                        slot_d[s] = retire_slot(slot_q[s]);
                    end else if (tick) begin
                        if (at_edge(slot_q[s])) slot_d[s] = retire_slot(slot_q[s]);
                        else                    slot_d[s] = step_slot(slot_q[s]);
                    end
                end
            end
            if (slot_free && (|arb_gnt)) begin
                for (int s = 0; s < NUM_SLOT; s++) begin
                    if (free_idx == 2'(s)) begin
                        slot_d[s].act   = 1'b1;
                        slot_d[s].x     = win_x;
                        slot_d[s].y     = win_y;
                        slot_d[s].dir   = dir_e'(win_dir);
                        slot_d[s].owner = win_idx;
                    end
                end
                grant_d = arb_gnt;
                ptr_d   = win_idx + 2'd1;
            end
            busy_d = '0;
            for (int s = 0; s < NUM_SLOT; s++) begin
                for (int r = 0; r < NUM_REQ; r++) begin
                    if (slot_d[s].act && (slot_d[s].owner == 2'(r))) busy_d[r] = 1'b1;
                end
            end
        end
    end

    // State registers; reset parks every slot off the field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SLOT; s++) begin
                slot_q[s].act   <= 1'b0;
                slot_q[s].x     <= OFF_FIELD;
                slot_q[s].y     <= OFF_FIELD;
                slot_q[s].dir   <= DIR_UP;
                slot_q[s].owner <= 2'd0;
            end
            busy_q  <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            for (int s = 0; s < NUM_SLOT; s++) slot_q[s] <= slot_d[s];
            busy_q  <= busy_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Flatten slot registers onto the output buses.
    always_comb begin
        for (int s = 0; s < NUM_SLOT; s++) begin
            shell_x[s*CW +: CW] = slot_q[s].x;
            shell_y[s*CW +: CW] = slot_q[s].y;
            shell_act[s]        = slot_q[s].act;
        end
    end

    assign busy  = busy_q;
    assign grant = grant_q;

endmodule

// File: tb/tb_shell_sched.sv
// Directed bench for shell_sched: a grant scoreboard checked by a monitor,
// plus direct state checks for movement, kill, enable and reset behaviour.
module tb_shell_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        tick;
    logic [3:0]  req;
    logic [19:0] tank_x, tank_y;
    logic [7:0]  tank_dir;
    logic [3:0]  kill;
    logic [19:0] shell_x, shell_y;
    logic [3:0]  shell_act, busy, grant;

    typedef struct {
        logic [3:0] gnt;
        int         slot;
        int         x;
        int         y;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    shell_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .tick      (tick),
        .req       (req),
        .tank_x    (tank_x),
        .tank_y    (tank_y),
        .tank_dir  (tank_dir),
        .kill      (kill),
        .shell_x   (shell_x),
        .shell_y   (shell_y),
        .shell_act (shell_act),
        .busy      (busy),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int sx(input int s);
        logic [19:0] v;
        v = shell_x >> (5 * s);
        return int'(v[4:0]);
    endfunction

    function automatic int sy(input int s);
        logic [19:0] v;
        v = shell_y >> (5 * s);
        return int'(v[4:0]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] g, input int s, input int x, input int y);
        exp_t e;
        e.gnt = g; e.slot = s; e.x = x; e.y = y;
        exp_q.push_back(e);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        #1;
    endtask

    // Monitor: every grant pulse must match the next expected allocation.
    always @(negedge clk) begin
        if (rst_n && grant !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_grant: got %b expected none", grant);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("grant", int'(grant), int'(e.gnt));
                chk("alloc_x", sx(e.slot), e.x);
                chk("alloc_y", sy(e.slot), e.y);
                chk("alloc_act", int'(shell_act[e.slot]), 1);
                chk("alloc_busy", int'(|(busy & e.gnt)), 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; tick = 1'b0; req = '0; kill = '0;
        tank_x = '0; tank_y = '0; tank_dir = '0;
        step();
        chk("rst_act", int'(shell_act), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_x", int'(shell_x), 20'hFFFFF);
        chk("rst_y", int'(shell_y), 20'hFFFFF);
        rst_n = 1'b1;

        // Single grant: tank0 at (7,7) heading up.
        enable = 1'b1; tank_x = 20'd7; tank_y = 20'd7; tank_dir = 8'h00; req = 4'b0001;
        push(4'b0001, 0, 7, 7);
        step();
        req = 4'b0000;
        step();
        chk("single_grant_clear", int'(grant), 0);
        chk("single_act", int'(shell_act), 1);
        chk("single_busy", int'(busy), 1);

        // Six ticks bring it to y=1, then y=0, then it retires.
        for (int i = 0; i < 6; i++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
        chk("move_y1", sy(0), 1);
        chk("move_x7", sx(0), 7);
        tick = 1'b1; step(); tick = 1'b0;
        chk("move_y0", sy(0), 0);
        chk("move_act", int'(shell_act), 1);
        tick = 1'b1; step(); tick = 1'b0;
        chk("edge_act", int'(shell_act), 0);
        chk("edge_x", sx(0), 31);
        chk("edge_y", sy(0), 31);
        chk("edge_busy", int'(busy), 0);

        // Four tanks all requesting: one grant per cycle in order.
        pulse_reset();
        tank_x   = {5'd16, 5'd11, 5'd6, 5'd1};
        tank_y   = {5'd5, 5'd4, 5'd3, 5'd2};
        tank_dir = 8'b11_10_01_00;
        req      = 4'b1111;
        push(4'b0001, 0, 1, 2);
        push(4'b0010, 1, 6, 3);
        push(4'b0100, 2, 11, 4);
        push(4'b1000, 3, 16, 5);
        for (int i = 0; i < 5; i++) step();
        chk("full_grant", int'(grant), 0);
        chk("full_act", int'(shell_act), 15);
        chk("full_busy", int'(busy), 15);
        chk("full_x", int'(shell_x), int'({5'd16, 5'd11, 5'd6, 5'd1}));
        chk("full_y", int'(shell_y), int'({5'd5, 5'd4, 5'd3, 5'd2}));

        // Kill slot2; tank2 gets it back a cycle later.
        kill = 4'b0100;
        step();
        kill = 4'b0000;
        chk("kill_act", int'(shell_act), 4'b1011);
        chk("kill_busy", int'(busy), 4'b1011);
        chk("kill_x", sx(2), 31);
        chk("kill_y", sy(2), 31);
        push(4'b0100, 2, 11, 4);
        step();
        step();

        // Kill slots 0 and 3: pointer sits at 3, so tank3 wins slot0 first.
        kill = 4'b1001;
        step();
        kill = 4'b0000;
        chk("kill2_act", int'(shell_act), 4'b0110);
        chk("kill2_busy", int'(busy), 4'b0110);
        push(4'b1000, 0, 16, 5);
        push(4'b0001, 3, 1, 2);
        step();
        step();
        step();
        req = 4'b0000;
        chk("rr_act", int'(shell_act), 15);

        // Grant coinciding with a tick: loaded unmoved, next tick retires it.
        pulse_reset();
        tank_x = {5'd0, 5'd0, 5'd24, 5'd0};
        tank_y = {5'd0, 5'd0, 5'd5, 5'd0};
        tank_dir = 8'b00_00_11_00;
        req = 4'b0010; tick = 1'b1;
        push(4'b0010, 0, 24, 5);
        step();
        req = 4'b0000; tick = 1'b0;
        chk("tickgrant_x", sx(0), 24);
        step();
        tick = 1'b1; step(); tick = 1'b0;
        chk("right_edge_act", int'(shell_act), 0);
        chk("right_edge_x", sx(0), 31);
        chk("right_edge_busy", int'(busy), 0);

        // Freeze with enable low, then asynchronous reset mid-flight.
        tank_x = 20'd3; tank_y = 20'd9; tank_dir = 8'b00_00_00_01;
        req = 4'b0001;
        push(4'b0001, 0, 3, 9);
        step();
        req = 4'b0000;
        step();
        enable = 1'b0; req = 4'b1111; tick = 1'b1; kill = 4'b1111;
        step(); step(); step();
        chk("frz_act", int'(shell_act), 1);
        chk("frz_busy", int'(busy), 1);
        chk("frz_grant", int'(grant), 0);
        chk("frz_x", int'(shell_x), int'({5'd31, 5'd31, 5'd31, 5'd3}));
        chk("frz_y", int'(shell_y), int'({5'd31, 5'd31, 5'd31, 5'd9}));
        #1 rst_n = 1'b0;
        #1;
        chk("arst_act", int'(shell_act), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_grant", int'(grant), 0);
        chk("arst_x", int'(shell_x), 20'hFFFFF);
        chk("arst_y", int'(shell_y), 20'hFFFFF);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
